denormalization: RTL and testbench

DENORMALIZATION -- requirements
Module: denormalization

---
 rtl/denormalization.sv | 141 ++++++++++++++
 tb/tb_denormalization.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/denormalization.sv
// Vector denormalizer: latches a signed input vector and streams it out
// LANES elements per beat, sign-extended, left-shifted and saturated.
module denormalization #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int SA_LENGTH = 256,
  parameter int LANES     = 16,
  localparam int BEATS    = SA_LENGTH / LANES,
  localparam int CW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                      Clk,
  input  logic                                      Rst,
  input  logic                                      InValid,
  output logic                                      InReady,
  input  logic signed [SA_LENGTH-1:0][IN_WIDTH-1:0] In,
  input  logic [7:0]                                ShiftAmmount,
  output logic                                      OutValid,
  input  logic                                      OutReady,
  output logic signed [LANES-1:0][OUT_WIDTH-1:0]    Out,
  output logic [CW-1:0]                             OutIndex,
  output logic                                      OutLast,
  input  logic                                      ClearOverflow,
  output logic                                      Overflow
);

  localparam int W = IN_WIDTH + OUT_WIDTH;

  localparam logic signed [W-1:0] MAXW =
    {{(IN_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [W-1:0] MINW =
    {{(IN_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0] MAXO =
    {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MINO =
    {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [LANES-1:0][IN_WIDTH-1:0] buf_q [BEATS];
  logic [7:0] shift_q;

  logic accept;
  logic fire;
  logic last;
  logic any_sat;
  logic [LANES-1:0] sat;
  logic [OUT_WIDTH:0] res;

  // {saturated, value}; the W-bit product holds any shift below OUT_WIDTH
  function automatic logic [OUT_WIDTH:0] shl_sat(
    input logic [IN_WIDTH-1:0] e,
    input logic [7:0]          s
  );
    logic signed [W-1:0] ext;
    logic signed [W-1:0] shd;
    ext = W'($signed(e));
    shd = ext <<< s;
    if (e == '0)
      shl_sat = '0;
    else if (int'(s) >= OUT_WIDTH)
      shl_sat = e[IN_WIDTH-1] ? {1'b1, MINO} : {1'b1, MAXO};
    else if (shd > MAXW)
      shl_sat = {1'b1, MAXO};
    else if (shd < MINW)
      shl_sat = {1'b1, MINO};
    else
      shl_sat = {1'b0, shd[OUT_WIDTH-1:0]};
  endfunction

  assign last   = (cnt_q == CW'(BEATS - 1));
  assign accept = InValid && InReady;
  assign fire   = OutValid && OutReady;

  always_comb begin
    state_d  = state_q;
    InReady  = 1'b0;
    OutValid = 1'b0;
    unique case (state_q)
      IDLE: begin
        InReady = !Rst;
        if (InValid && !Rst)
          state_d = STREAM;
      end
      STREAM: begin
        OutValid = 1'b1;
        if (OutReady && last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      Overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= '0;
      else if (fire)
        cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (fire && any_sat)
        Overflow <= 1'b1;
      else if (ClearOverflow)
        Overflow <= 1'b0;
    end
  end

  // Payload needs no reset; it is only observed after an acceptance
  always_ff @(posedge Clk) begin
    if (accept) begin
      shift_q <= ShiftAmmount;
      for (int k = 0; k < BEATS; k++)
        for (int j = 0; j < LANES; j++)
          buf_q[k][j] <= In[k*LANES+j];
    end
  end

  always_comb begin
    Out = '0;
    sat = '0;
    res = '0;
    if (state_q == STREAM) begin
      for (int j = 0; j < LANES; j++) begin
        res    = shl_sat(buf_q[cnt_q][j], shift_q);
        sat[j] = res[OUT_WIDTH];
        Out[j] = res[OUT_WIDTH-1:0];
      end
    end
  end

  assign any_sat  = |sat;
  assign OutIndex = cnt_q;
  assign OutLast  = (state_q == STREAM) && last;

endmodule

// File: tb/tb_denormalization.sv
// Randomized bench for denormalization with a queue-based
// behavioural model and a per-cycle compare process.
module tb_denormalization;

  localparam int IW = 8;
  localparam int OW = 32;
  localparam int SA = 256;
  localparam int LN = 16;
  localparam int NB = SA / LN;

  logic Clk = 0;
  logic Rst = 0;
  logic InValid = 0;
  logic InReady;
  logic [SA-1:0][IW-1:0] In = '0;
  logic [7:0] ShiftAmmount = '0;
  logic OutValid;
  logic OutReady = 1;
  logic [LN-1:0][OW-1:0] Out;
  logic [3:0] OutIndex;
  logic OutLast;
  logic ClearOverflow = 0;
  logic Overflow;

  denormalization #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .SA_LENGTH(SA), .LANES(LN)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .InValid(InValid), .InReady(InReady),
    .In(In), .ShiftAmmount(ShiftAmmount),
    .OutValid(OutValid), .OutReady(OutReady),
    .Out(Out), .OutIndex(OutIndex), .OutLast(OutLast),
    .ClearOverflow(ClearOverflow), .Overflow(Overflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [LN-1:0][OW-1:0] d;
    int idx;
    bit last;
    bit sat;
  } beat_t;

  beat_t q[$];
  bit exp_ov = 0;
  bit bp = 0;
  int ntests = 0;
  int nfail = 0;

  task automatic chk(string nm, logic [511:0] a, logic [511:0] e);
    ntests++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // {saturated, value}: exact value v*2^s clamped to 32-bit signed
  function automatic logic [32:0] mdl(int v, int s);
    longint p;
    if (v == 0) return '0;
    if (s >= 32)
      return (v < 0) ? {1'b1, 32'h80000000} : {1'b1, 32'h7fffffff};
    p = longint'(v) * (64'sd1 <<< s);
    if (p > 64'sd2147483647) return {1'b1, 32'h7fffffff};
    if (p < -64'sd2147483648) return {1'b1, 32'h80000000};
    return {1'b0, 32'(p)};
  endfunction

  task automatic push_vec();
    beat_t b;
    logic [32:0] r;
    for (int k = 0; k < NB; k++) begin
      b.sat = 0;
      for (int j = 0; j < LN; j++) begin
        r = mdl(int'($signed(In[k*LN+j])), int'(ShiftAmmount));
        b.d[j] = r[31:0];
        b.sat = b.sat | r[32];
      end
      b.idx = k;
      b.last = (k == NB - 1);
      q.push_back(b);
    end
  endtask

  always @(negedge Clk) begin
    bit set;
    if (Rst) begin
      chk("rst_outvalid", OutValid, 1'b0);
      chk("rst_inready", InReady, 1'b0);
      chk("rst_out", Out, '0);
      chk("rst_outlast", OutLast, 1'b0);
      chk("rst_index", OutIndex, '0);
      chk("rst_overflow", Overflow, 1'b0);
      q.delete();
      exp_ov = 0;
    end else begin
      chk("inready", InReady, q.size() == 0);
      chk("outvalid", OutValid, q.size() != 0);
      chk("overflow", Overflow, exp_ov);
      set = 0;
      if (OutValid && q.size() != 0) begin
        chk("out", Out, q[0].d);
        chk("index", OutIndex, q[0].idx);
        chk("outlast", OutLast, q[0].last);
        if (OutReady) begin
          set = q[0].sat;
          q.pop_front();
        end
      end
      if (set) exp_ov = 1;
      else if (ClearOverflow) exp_ov = 0;
      if (InValid && InReady) push_vec();
    end
  end

  always @(posedge Clk) begin
    #1;
    OutReady = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send(input logic [7:0] sh);
    int n = 0;
    @(posedge Clk); #1;
    ShiftAmmount = sh;
    InValid = 1;
    @(negedge Clk);
    while (!InReady && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (!InReady) chk("send_timeout", 1'b0, 1'b1);
    @(posedge Clk); #1;
    InValid = 0;
  endtask

  // Streams garbage at the input while busy; it must be ignored
  task automatic wait_idle();
    int n = 0;
    @(negedge Clk);
    while (!InReady && n < 2000) begin
      @(posedge Clk); #1;
      if (OutValid && !OutLast) begin
        InValid = 1;
        ShiftAmmount = 8'($urandom);
        for (int i = 0; i < SA; i++) In[i] = 8'($urandom);
      end else begin
        InValid = 0;
      end
      @(negedge Clk);
      n++;
    end
    if (!InReady) chk("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_beat(input int k);
    int n = 0;
    @(negedge Clk);
    while (!(OutValid && OutIndex == 4'(k)) && n < 2000) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 2000) chk("beat_timeout", 1'b0, 1'b1);
  endtask

  task automatic clear_ov();
    @(posedge Clk); #1 ClearOverflow = 1;
    @(posedge Clk); #1 ClearOverflow = 0;
    @(negedge Clk);
    chk("ovf_cleared", Overflow, 1'b0);
  endtask

  initial begin
    int b;
    int mode;
    logic [7:0] sh;
    #1 Rst = 1;
    repeat (3) @(posedge Clk);
    #1 Rst = 0;

    chk("mdl_a", mdl(-128, 4), {1'b0, 32'hFFFFF800});
    chk("mdl_b", mdl(127, 4), {1'b0, 32'd2032});
    chk("mdl_c", mdl(127, 25), {1'b1, 32'h7fffffff});
    chk("mdl_d", mdl(-128, 24), {1'b0, 32'h80000000});
    chk("mdl_e", mdl(-128, 25), {1'b1, 32'h80000000});
    chk("mdl_f", mdl(-1, 200), {1'b1, 32'h80000000});
    chk("mdl_g", mdl(0, 200), 33'd0);

    for (int i = 0; i < SA; i++) In[i] = 8'(i - 128);
    send(8'd4);
    wait_beat(0);
    chk("basic_b0l0", Out[0], 32'hFFFFF800);
    wait_beat(15);
    chk("basic_b15l15", Out[15], 32'd2032);
    chk("basic_last", OutLast, 1'b1);
    wait_idle();
    chk("basic_ovf", Overflow, 1'b0);

    for (int i = 0; i < SA; i++) In[i] = 8'd127;
    send(8'd25);
    wait_beat(0);
    chk("satp_l0", Out[0], 32'h7fffffff);
    wait_idle();
    chk("satp_ovf", Overflow, 1'b1);
    clear_ov();

    for (int i = 0; i < SA; i++) In[i] = 8'h80;
    send(8'd24);
    wait_beat(0);
    chk("minexact_l3", Out[3], 32'h80000000);
    wait_idle();
    chk("minexact_ovf", Overflow, 1'b0);
    for (int i = 0; i < SA; i++) In[i] = 8'h80;
    send(8'd25);
    wait_idle();
    chk("satn_ovf", Overflow, 1'b1);
    clear_ov();

    for (int i = 0; i < SA; i++) In[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
    send(8'd200);
    wait_beat(3);
    chk("big_l0", Out[0], 32'h0);
    chk("big_l1", Out[1], 32'h80000000);
    wait_idle();
    clear_ov();

    for (int i = 0; i < SA; i++) In[i] = 8'h00;
    send(8'd200);
    wait_idle();
    chk("zero_noflag", Overflow, 1'b0);

    for (int i = 0; i < SA; i++) In[i] = 8'd127;
    send(8'd25);
    @(posedge Clk); #1 ClearOverflow = 1;
    wait_idle();
    chk("setprio_ovf", Overflow, 1'b1);
    @(posedge Clk); #1 ClearOverflow = 0;
    @(negedge Clk);
    chk("clear_ovf", Overflow, 1'b0);

    bp = 1;
    for (int v = 0; v < 25; v++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < SA; i++) begin
        b = $urandom;
        if (mode == 0 && b[8]) b = 0;
        In[i] = 8'(b);
      end
      if ($urandom_range(0, 4) == 0) sh = 8'($urandom_range(32, 255));
      else sh = 8'($urandom_range(0, 30));
      @(posedge Clk); #1 ClearOverflow = 1'($urandom_range(0, 1));
      send(sh);
      wait_idle();
    end
    @(posedge Clk); #1 ClearOverflow = 0;
    bp = 0;

    for (int i = 0; i < SA; i++) In[i] = 8'($urandom);
    send(8'($urandom_range(0, 20)));
    wait_beat(7);
    #1 Rst = 1;
    #1;
    chk("midrst_outvalid", OutValid, 1'b0);
    chk("midrst_inready", InReady, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Rst = 0;
    @(negedge Clk);
    chk("midrst_release", InReady, 1'b1);
    for (int i = 0; i < SA; i++) In[i] = 8'($urandom);
    send(8'd3);
    @(negedge Clk);
    chk("midrst_first_idx", OutIndex, 4'd0);
    wait_idle();

    repeat (2) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
